// File: rtl/grid_cursor_ctrl.sv
// ----------------------------------------------------------------------------
// grid_cursor_ctrl
// Cursor controller for the square-selection stage of the color-matching game.
// Moves a highlight over a ROWS x COLS grid from debounced direction buttons,
// with selectable edge behaviour (saturate / torus / linear L-R), hold-to-
// auto-repeat, and a registered select pulse reporting the picked cell.
//
// Ports
//   clk25MHz   system clock
//   rst_n      synchronous reset, active-low
//   up/down/right/left  debounced direction buttons (clock-synchronous)
//   sel        debounced select button
//   step       current game step; the cursor is live only at ACTIVE_STEP
//   variety    highlighted cell index = row*COLS + col
//   row, col   highlighted cell coordinates
//   moved      1-cycle pulse whenever variety changes
//   sel_valid  1-cycle pulse on an accepted select
//   sel_index  cell index captured at the last accepted select
// ----------------------------------------------------------------------------
module grid_cursor_ctrl #(
    parameter int unsigned ROWS        = 2,
    parameter int unsigned COLS        = 2,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned INIT_IDX    = 0,
    parameter int unsigned WRAP_MODE   = 1,
    parameter int unsigned REPEAT_DLY  = 12_500_000,
    parameter int unsigned REPEAT_RATE = 2_500_000,
    parameter int unsigned STEP_W      = 3,
    parameter int unsigned ACTIVE_STEP = 0
) (
    input  logic                                          clk25MHz,
    input  logic                                          rst_n,
    input  logic                                          up,
    input  logic                                          down,
    input  logic                                          right,
    input  logic                                          left,
    input  logic                                          sel,
    input  logic [STEP_W-1:0]                             step,
    output logic [IDX_W-1:0]                              variety,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]    row,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]    col,
    output logic                                          moved,
    output logic                                          sel_valid,
    output logic [IDX_W-1:0]                              sel_index
);

    localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'((REPEAT_DLY  > 0) ? REPEAT_DLY  - 1 : 0);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] INIT_ROW  = ROW_W'(INIT_IDX / COLS);
    localparam logic [COL_W-1:0] INIT_COL  = COL_W'(INIT_IDX % COLS);
    localparam logic [IDX_W-1:0] INIT_VAR  = IDX_W'(INIT_IDX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD_DLY,
        ST_HOLD_RPT,
        ST_LOCK
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_RIGHT,
        DIR_LEFT
    } dir_e;

    // With repeat disabled a press moves once and then waits for release.
    localparam state_e ST_AFTER_PRESS = (REPEAT_DLY > 0) ? ST_HOLD_DLY : ST_LOCK;

    state_e             state_q,     state_d;
    dir_e               cap_dir_q,   cap_dir_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [ROW_W-1:0]   row_q,       row_d;
    logic [COL_W-1:0]   col_q,       col_d;
    logic [IDX_W-1:0]   variety_q,   variety_d;
    logic               moved_q,     moved_d;
    logic               sel_prev_q,  sel_prev_d;
    logic               sel_valid_q, sel_valid_d;
    logic [IDX_W-1:0]   sel_index_q, sel_index_d;

    logic               active;
    logic               dir_any;
    dir_e               pri_dir;
    logic               cap_btn;
    logic               do_move;
    dir_e               move_dir;
    logic [ROW_W-1:0]   row_mv;
    logic [COL_W-1:0]   col_mv;

    assign active  = (step == STEP_W'(ACTIVE_STEP));
    assign dir_any = up | down | right | left;

    // Highest-priority pressed direction: up > down > right > left.
    always_comb begin
        pri_dir = DIR_LEFT;
        if (up) begin
            pri_dir = DIR_UP;
        end else if (down) begin
            pri_dir = DIR_DOWN;
        end else if (right) begin
            pri_dir = DIR_RIGHT;
        end
    end

    // Level of the button that started the current hold.
    always_comb begin
        cap_btn = 1'b0;
        unique case (cap_dir_q)
            DIR_UP:    cap_btn = up;
            DIR_DOWN:  cap_btn = down;
            DIR_RIGHT: cap_btn = right;
            DIR_LEFT:  cap_btn = left;
            default:   cap_btn = 1'b0;
        endcase
    end

    // Press / hold / repeat sequencing.
    always_comb begin
        state_d   = state_q;
        cap_dir_d = cap_dir_q;
        cnt_d     = cnt_q;
        do_move   = 1'b0;
        move_dir  = cap_dir_q;

        if (!active) begin
            state_d = ST_LOCK;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dir_any) begin
                        do_move   = 1'b1;
                        move_dir  = pri_dir;
                        cap_dir_d = pri_dir;
                        cnt_d     = '0;
                        state_d   = ST_AFTER_PRESS;
                    end
                end
                ST_HOLD_DLY: begin
                    if (!cap_btn) begin
                        state_d = ST_LOCK;
                    end else if (cnt_q == DLY_LAST) begin
                        do_move = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_HOLD_RPT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HOLD_RPT: begin
                    if (!cap_btn) begin
                        state_d = ST_LOCK;
                    end else if (cnt_q == RATE_LAST) begin
                        do_move = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (!dir_any) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_LOCK;
            endcase
        end
    end

    // Candidate position after one step in move_dir. A blocked saturating
    // move leaves the position unchanged. In linear mode a horizontal step
    // off the end of a row carries into the neighbouring row, which is the
    // same as +-1 on the flat index modulo ROWS*COLS.
    always_comb begin
        row_mv = row_q;
        col_mv = col_q;
        unique case (move_dir)
            DIR_UP: begin
                if (row_q != '0) begin
                    row_mv = row_q - 1'b1;
                end else if (WRAP_MODE != 0) begin
                    row_mv = ROW_LAST;
                end
            end
            DIR_DOWN: begin
                if (row_q != ROW_LAST) begin
                    row_mv = row_q + 1'b1;
                end else if (WRAP_MODE != 0) begin
                    row_mv = '0;
                end
            end
            DIR_RIGHT: begin
                if (col_q != COL_LAST) begin
                    col_mv = col_q + 1'b1;
                end else if (WRAP_MODE == 1) begin
                    col_mv = '0;
                end else if (WRAP_MODE == 2) begin
                    col_mv = '0;
                    row_mv = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end
            end
            DIR_LEFT: begin
                if (col_q != '0) begin
                    col_mv = col_q - 1'b1;
                end else if (WRAP_MODE == 1) begin
                    col_mv = COL_LAST;
                end else if (WRAP_MODE == 2) begin
                    col_mv = COL_LAST;
                    row_mv = (row_q == '0) ? ROW_LAST : row_q - 1'b1;
                end
            end
            default: begin
                row_mv = row_q;
                col_mv = col_q;
            end
        endcase
    end

    // Position, index and pulse outputs.
    always_comb begin
        row_d       = do_move ? row_mv : row_q;
        col_d       = do_move ? col_mv : col_q;
        variety_d   = IDX_W'(row_d) * IDX_W'(COLS) + IDX_W'(col_d);
        // A wrap onto the same cell (single-row/column grid) is not a move.
        moved_d     = (variety_d != variety_q);

        // sel_prev follows sel even while inactive, so a press held across
        // activation is not seen as a fresh edge.
        sel_prev_d  = sel;
        sel_valid_d = active & sel & ~sel_prev_q;
        // Captures the pre-move index when a move lands in the same cycle.
        sel_index_d = sel_valid_d ? variety_q : sel_index_q;
    end

    always_ff @(posedge clk25MHz) begin
        if (!rst_n) begin
            state_q     <= ST_LOCK;
            cap_dir_q   <= DIR_UP;
            cnt_q       <= '0;
            row_q       <= INIT_ROW;
            col_q       <= INIT_COL;
            variety_q   <= INIT_VAR;
            moved_q     <= 1'b0;
            sel_prev_q  <= 1'b1;
            sel_valid_q <= 1'b0;
            sel_index_q <= '0;
        end else begin
            state_q     <= state_d;
            cap_dir_q   <= cap_dir_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            variety_q   <= variety_d;
            moved_q     <= moved_d;
            sel_prev_q  <= sel_prev_d;
            sel_valid_q <= sel_valid_d;
            sel_index_q <= sel_index_d;
        end
    end

    assign variety   = variety_q;
    assign row       = row_q;
    assign col       = col_q;
    assign moved     = moved_q;
    assign sel_valid = sel_valid_q;
    assign sel_index = sel_index_q;

endmodule
